spi_ring_buffer: RTL
====================

Name: spi_ring_buffer

Overview:
- Parametrised successor to the SPI-side processing-unit buffer: a circular FIFO between the SPI transceiver and the processing-unit datapath.
- Write and read strobes are edge-qualified, so a strobe held high for several cycles moves exactly one word.
- Adds an independent read port, full/empty/count status, sticky overflow/underflow flags and a synchronous flush.

Parameters:
DATA_WIDTH, 8, word width in bits
BUF_SIZE, 6, depth in words; any value >= 2, not restricted to a power of two
ADDR_WIDTH, $clog2(BUF_SIZE), pointer width
CNT_WIDTH, $clog2(BUF_SIZE+1), occupancy counter width
EDGE_MODE, 1, 1 = strobes act on rising edge only; 0 = strobes act every cycle they are high

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-low reset
wr_strobe  input  1  write request (ready from the SPI side)
data_in  input  DATA_WIDTH  word to write
rd_strobe  input  1  read request
data_out  output  DATA_WIDTH  last word read, registered
flush  input  1  synchronous clear of buffer contents
count  output  CNT_WIDTH  current occupancy
empty  output  1  count == 0
full  output  1  count == BUF_SIZE
overflow  output  1  sticky: a write was dropped
underflow  output  1  sticky: a read was rejected

Behaviour:
- Reset (rst=0, asynchronous):
  - wr_ptr=0, rd_ptr=0, count=0, data_out=0.
  - empty=1, full=0, overflow=0, underflow=0.
  - Strobe-history registers cleared to 0.
  - Memory contents are not reset.
- Strobe qualification:
  - EDGE_MODE=1: wr_pulse = wr_strobe & ~wr_q, where wr_q is wr_strobe registered; rd_pulse is formed the same way.
  - EDGE_MODE=0: pulse equals the strobe.
  - History registers update every cycle, including flush cycles.
  - A strobe already high when reset releases counts as a rising edge on the first clock.
- Write (wr_pulse and accepted):
  - mem[wr_ptr] <= data_in.
  - wr_ptr increments, wrapping from BUF_SIZE-1 to 0 by explicit compare, not modulo-2^n.
- Read (rd_pulse and accepted):
  - data_out <= mem[rd_ptr] on the same edge, so it is visible one cycle after the pulse.
  - rd_ptr increments with the same wrap rule.
  - data_out holds its value whenever no read is accepted.
- Acceptance:
  - Read is accepted iff !empty. No write-to-read bypass.
  - Write is accepted iff !full, or full and a read is accepted in the same cycle.
- Count update:
  - Write only: +1.
  - Read only: -1.
  - Both, or neither: unchanged.
- Error flags:
  - Write dropped (wr_pulse, full, no accepted read): overflow <= 1. Memory and pointers are unchanged.
  - Read rejected (rd_pulse, empty): underflow <= 1. data_out holds.
  - Simultaneous write and read on empty: the write is accepted, the read is rejected, underflow is set and count becomes 1.
  - Both flags stay set until flush or reset.
- Flush (synchronous, highest priority):
  - Pointers and count go to 0; overflow and underflow are cleared.
  - Any write or read in the same cycle is ignored.
  - data_out is not changed.
- Status timing: empty, full and count are registered or derived from registered count, and reflect the state after the most recent edge.
- Reset mid-operation: all state returns to reset values immediately, independent of clk.

Test Plan:
1. Reset, then write 2 with wr_strobe high for 2 cycles (EDGE_MODE=1) -> count=1, exactly one entry; read pulse -> data_out=2 one cycle later, empty=1.
2. Write 2,3,4,5,6,7 (six separate strobe edges) -> full=1, count=6; then write 8 -> overflow=1, count=6; six reads -> data_out sequence 2..7, empty=1.
3. Wrap-around: write 4, read 4, write 5 more words 10..14 -> wr_ptr wraps past index 5; reads return 10..14 in order, count returns to 0.
4. Full buffer, simultaneous write 9 and read -> read returns the oldest word, count stays 6, overflow stays 0; the final read returns 9.
5. Empty buffer, simultaneous write 0x55 and read -> underflow=1, data_out unchanged, count=1; the next read -> data_out=0x55.
6. Count=3 with flags set, assert flush together with a write -> count=0, empty=1, overflow=underflow=0, and the write is ignored. Then drop rst asynchronously mid-cycle -> all outputs go to reset values before the next clk edge.

Source files
------------

// File: rtl/spi_ring_buffer.sv
// spi_ring_buffer: circular FIFO between the SPI transceiver and the
// processing-unit datapath. Write/read strobes are optionally edge-qualified,
// so a strobe held high for several cycles moves exactly one word. Adds
// occupancy status, sticky overflow/underflow flags and a synchronous flush.
module spi_ring_buffer #(
    parameter int DATA_WIDTH = 8,
    parameter int BUF_SIZE   = 6,
    parameter int ADDR_WIDTH = $clog2(BUF_SIZE),
    parameter int CNT_WIDTH  = $clog2(BUF_SIZE + 1),
    parameter int EDGE_MODE  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_strobe,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  rd_strobe,
    output logic [DATA_WIDTH-1:0] data_out,
    input  logic                  flush,
    output logic [CNT_WIDTH-1:0]  count,
    output logic                  empty,
    output logic                  full,
    output logic                  overflow,
    output logic                  underflow
);

    // Depth need not be a power of two, so pointers wrap on an explicit
    // compare against the last index rather than by natural overflow.
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(BUF_SIZE - 1);
    localparam logic [CNT_WIDTH-1:0]  FULL_CNT = CNT_WIDTH'(BUF_SIZE);

    if (BUF_SIZE < 2) begin : g_bad_size
        $error("spi_ring_buffer: BUF_SIZE must be at least 2");
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] mem_q [BUF_SIZE];

    logic [ADDR_WIDTH-1:0] wr_ptr_q,    wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q,    rd_ptr_d;
    logic [CNT_WIDTH-1:0]  count_q,     count_d;
    logic [DATA_WIDTH-1:0] data_out_q,  data_out_d;
    logic                  overflow_q,  overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  wr_hist_q,   wr_hist_d;
    logic                  rd_hist_q,   rd_hist_d;

    // ------------------------------------------------------------------
    // Qualification / acceptance
    // ------------------------------------------------------------------
    logic wr_pulse;
    logic rd_pulse;
    logic empty_int;
    logic full_int;
    logic rd_acc;
    logic wr_acc;

    function automatic logic [ADDR_WIDTH-1:0] ptr_inc(input logic [ADDR_WIDTH-1:0] p);
        return (p == LAST_IDX) ? '0 : p + 1'b1;
    endfunction

    // Turn raw strobes into single-cycle requests and decide which are taken.
    always_comb begin
        wr_pulse = wr_strobe;
        rd_pulse = rd_strobe;
        if (EDGE_MODE != 0) begin
            wr_pulse = wr_strobe & ~wr_hist_q;
            rd_pulse = rd_strobe & ~rd_hist_q;
        end

        empty_int = (count_q == '0);
        full_int  = (count_q == FULL_CNT);

        // Flush outranks everything; a read never sees a same-cycle write,
        // and a full buffer can still take a write if a read frees a slot.
        rd_acc = rd_pulse & ~empty_int & ~flush;
        wr_acc = wr_pulse & ~flush & (~full_int | rd_acc);
    end

    // ------------------------------------------------------------------
    // Next-state
    // ------------------------------------------------------------------
    // Compute pointers, occupancy, output word, sticky flags and history.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        data_out_d  = data_out_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        // History always tracks the raw strobes, flush or not, so a strobe
        // held across a flush does not fire again on release.
        wr_hist_d   = wr_strobe;
        rd_hist_d   = rd_strobe;

        if (flush) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (rd_acc) begin
                rd_ptr_d   = ptr_inc(rd_ptr_q);
                data_out_d = mem_q[rd_ptr_q];
            end

            case ({wr_acc, rd_acc})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase

            if (wr_pulse && !wr_acc) begin
                overflow_d = 1'b1;
            end
            if (rd_pulse && !rd_acc) begin
                underflow_d = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    // Control/status state with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            data_out_q  <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            wr_hist_q   <= 1'b0;
            rd_hist_q   <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            data_out_q  <= data_out_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            wr_hist_q   <= wr_hist_d;
            rd_hist_q   <= rd_hist_d;
        end
    end

    // Storage array: no reset, only written on an accepted write. A read of
    // the same slot in the same cycle sees the old (oldest) word.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign data_out  = data_out_q;
    assign count     = count_q;
    assign empty     = empty_int;
    assign full      = full_int;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule
